// File: rtl/kftvga_video_timing.sv
// Raster timing generator: 640x480@60 counters, stage-0 fetch decode, and a
// PIPE_DELAY-deep sync/enable pipeline. Optional vblank IRQ under KFTVGA_VBLANK_IRQ_EN.
module kftvga_video_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int PIPE_DELAY  = 2
) (
  input  logic       video_clock,
  input  logic       video_reset,
`ifdef KFTVGA_VBLANK_IRQ_EN
  input  logic       irq_clear,
  output logic       vblank_irq,
`endif
  output logic [9:0] fetch_x,
  output logic [9:0] fetch_y,
  output logic       fetch_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       display_enable,
  output logic       video_h_sync,
  output logic       video_v_sync
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("kftvga_video_timing: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
    $error("kftvga_video_timing: PIPE_DELAY must be in 1..4");
  end

  // Segment boundaries held at 11 bits so a total of exactly 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  logic [9:0]  h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic [10:0] h_ext, v_ext;

  // NOTE: every variable gets a default first, so no path through the block can infer a latch.
  always_comb begin
    h_count_d = h_count_q + 10'd1;
    v_count_d = v_count_q;
    if (h_count_q == H_LAST) begin
      h_count_d = '0;
      if (v_count_q == V_LAST) begin
        v_count_d = '0;
      end else begin
        v_count_d = v_count_q + 10'd1;
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge video_clock) begin
    if (video_reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  assign h_ext = {1'b0, h_count_q};
  assign v_ext = {1'b0, v_count_q};

  logic h_active, v_active, h_in_sync, v_in_sync;
  logic raw_de, raw_hs, raw_vs;

  assign h_active  = (h_ext < H_ACT_END);
  assign v_active  = (v_ext < V_ACT_END);
  assign h_in_sync = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
  assign v_in_sync = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

  assign raw_de = h_active & v_active & ~video_reset;
  assign raw_hs = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign raw_vs = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // Stage-0 fetch interface: zero latency from the counters, silenced while reset is held.
  assign fetch_valid = raw_de;
  assign fetch_x     = raw_de ? h_count_q : '0;
  assign fetch_y     = raw_de ? v_count_q : '0;
  assign line_start  = ~video_reset & (h_count_q == '0) & v_active;
  assign frame_start = ~video_reset & (h_count_q == '0) & (v_count_q == '0);

  logic [PIPE_DELAY-1:0] de_pipe_q, de_pipe_d;
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;

  always_comb begin
    de_pipe_d    = de_pipe_q;
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    de_pipe_d[0] = raw_de;
    hs_pipe_d[0] = raw_hs;
    vs_pipe_d[0] = raw_vs;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      de_pipe_d[i] = de_pipe_q[i-1];
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
    end
  end

  // NOTE: every pipeline stage takes reset, so a mid-frame reset cannot leak a stale pulse to the pins.
  always_ff @(posedge video_clock) begin
    if (video_reset) begin
      de_pipe_q <= '0;
      hs_pipe_q <= {PIPE_DELAY{~SYNC_ACTIVE}};
      vs_pipe_q <= {PIPE_DELAY{~SYNC_ACTIVE}};
    end else begin
      de_pipe_q <= de_pipe_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign display_enable = de_pipe_q[PIPE_DELAY-1];
  assign video_h_sync   = hs_pipe_q[PIPE_DELAY-1];
  assign video_v_sync   = vs_pipe_q[PIPE_DELAY-1];

`ifdef KFTVGA_VBLANK_IRQ_EN
  localparam logic [9:0] V_ACT10 = 10'(V_ACTIVE);

  logic irq_q, irq_d, irq_set;

  // Set on the first clock of vertical blanking; a simultaneous clear loses to the set.
  assign irq_set = ~video_reset & (h_count_q == '0) & (v_count_q == V_ACT10);

  always_comb begin
    irq_d = irq_set | (irq_q & ~irq_clear);
  end

  always_ff @(posedge video_clock) begin
    if (video_reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign vblank_irq = irq_q;
`endif

endmodule

// File: tb/tb_kftvga_video_timing.sv
// Directed bench: default-timing instance for reset/line/mid-sync reset, and a
// small-geometry instance (active-high sync, PIPE_DELAY=3) for frame, wrap and IRQ.
module tb_kftvga_video_timing;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       rst_b;
  logic [9:0] fx_b, fy_b;
  logic       fv_b, ls_b, fs_b, de_b, hs_b, vs_b;

  logic       rst_s;
  logic [9:0] fx_s, fy_s;
  logic       fv_s, ls_s, fs_s, de_s, hs_s, vs_s;

`ifdef KFTVGA_VBLANK_IRQ_EN
  logic irq_b, irq_s, irq_clear_s;
`endif

  kftvga_video_timing dut_b (
    .video_clock    (clk),
    .video_reset    (rst_b),
`ifdef KFTVGA_VBLANK_IRQ_EN
    .irq_clear      (1'b0),
    .vblank_irq     (irq_b),
`endif
    .fetch_x        (fx_b),
    .fetch_y        (fy_b),
    .fetch_valid    (fv_b),
    .line_start     (ls_b),
    .frame_start    (fs_b),
    .display_enable (de_b),
    .video_h_sync   (hs_b),
    .video_v_sync   (vs_b)
  );

  kftvga_video_timing #(
    .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
    .V_ACTIVE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE(1'b1), .PIPE_DELAY(3)
  ) dut_s (
    .video_clock    (clk),
    .video_reset    (rst_s),
`ifdef KFTVGA_VBLANK_IRQ_EN
    .irq_clear      (irq_clear_s),
    .vblank_irq     (irq_s),
`endif
    .fetch_x        (fx_s),
    .fetch_y        (fy_s),
    .fetch_valid    (fv_s),
    .line_start     (ls_s),
    .frame_start    (fs_s),
    .display_enable (de_s),
    .video_h_sync   (hs_s),
    .video_v_sync   (vs_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first_de, last_de, de_cnt, first_hs, hs_cnt, ls_pos, vs_low;
  int fs_cnt, ls_cnt, vs_cnt, first_vs, first_irq;

  initial begin
    rst_b = 1'b1;
    rst_s = 1'b1;
`ifdef KFTVGA_VBLANK_IRQ_EN
    irq_clear_s = 1'b0;
`endif

    // Reset held for 4 clocks on the default instance.
    repeat (4) tick();
    chk("rst_hsync", hs_b, 1);
    chk("rst_vsync", vs_b, 1);
    chk("rst_de", de_b, 0);
    chk("rst_fetch_valid", fv_b, 0);
    chk("rst_frame_start", fs_b, 0);
    chk("rst_line_start", ls_b, 0);

    rst_b = 1'b0;
    #1;
    chk("rel_frame_start", fs_b, 1);
    chk("rel_line_start", ls_b, 1);
    chk("rel_fetch_x", fx_b, 0);
    chk("rel_fetch_y", fy_b, 0);
    chk("rel_fetch_valid", fv_b, 1);
    chk("rel_de_not_yet", de_b, 0);

    // One full line plus the pipeline tail, sampled at each state k after release.
    first_de = -1; last_de = -1; de_cnt = 0;
    first_hs = -1; hs_cnt = 0; ls_pos = -1; vs_low = 0;
    for (int k = 0; k < 802; k++) begin
      if (de_b) begin
        de_cnt++;
        if (first_de < 0) first_de = k;
        last_de = k;
      end
      if (!hs_b) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = k;
      end
      if (!vs_b) vs_low++;
      if (k > 0 && ls_b && ls_pos < 0) ls_pos = k;
      if (k == 639) begin
        chk("line_fetch_x_last", fx_b, 639);
        chk("line_fetch_valid_last", fv_b, 1);
      end
      if (k == 640) begin
        chk("line_fetch_valid_porch", fv_b, 0);
        chk("line_fetch_x_porch", fx_b, 0);
      end
      tick();
    end
    chk("line_de_first", first_de, 2);
    chk("line_de_last", last_de, 641);
    chk("line_de_count", de_cnt, 640);
    chk("line_hs_first", first_hs, 658);
    chk("line_hs_count", hs_cnt, 96);
    chk("line_period", ls_pos, 800);
    chk("line_vs_quiet", vs_low, 0);

    // Advance to h=700 of line 2 (inside hsync), then pulse reset for one clock.
    repeat (2300 - 802) tick();
    chk("midsync_hs_low", hs_b, 0);
    chk("midsync_fetch_valid", fv_b, 0);
    rst_b = 1'b1;
    tick();
    chk("midrst_hsync", hs_b, 1);
    chk("midrst_de", de_b, 0);
    chk("midrst_vsync", vs_b, 1);
    chk("midrst_fetch_valid", fv_b, 0);
    rst_b = 1'b0;
    #1;
    chk("midrst_frame_start", fs_b, 1);
    chk("midrst_fetch_x", fx_b, 0);
    chk("midrst_fetch_y", fy_b, 0);
    chk("midrst_fetch_valid_rel", fv_b, 1);
    first_de = -1; hs_cnt = 0;
    for (int k = 0; k < 658; k++) begin
      if (!hs_b) hs_cnt++;
      if (de_b && first_de < 0) first_de = k;
      tick();
    end
    chk("midrst_no_stale_hs", hs_cnt, 0);
    chk("midrst_de_restart", first_de, 2);

    // Small instance: 20x13 total, active-high sync, PIPE_DELAY=3.
    chk("s_rst_hsync", hs_s, 0);
    chk("s_rst_vsync", vs_s, 0);
    chk("s_rst_de", de_s, 0);
    rst_s = 1'b0;
    #1;
    chk("s_rel_frame_start", fs_s, 1);

    fs_cnt = 0; ls_cnt = 0; vs_cnt = 0; first_vs = -1;
    de_cnt = 0; first_de = -1; hs_cnt = 0; first_irq = -1;
    for (int k = 0; k < 260; k++) begin
      if (fs_s) fs_cnt++;
      if (ls_s) ls_cnt++;
      if (de_s) begin
        de_cnt++;
        if (first_de < 0) first_de = k;
      end
      if (hs_s) hs_cnt++;
      if (vs_s) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = k;
      end
      if (k == 45) begin
        chk("s_mid_fetch_x", fx_s, 5);
        chk("s_mid_fetch_y", fy_s, 2);
        chk("s_mid_fetch_valid", fv_s, 1);
      end
      if (k == 259) begin
        chk("s_last_frame_start", fs_s, 0);
        chk("s_last_fetch_valid", fv_s, 0);
        chk("s_last_fetch_x", fx_s, 0);
      end
`ifdef KFTVGA_VBLANK_IRQ_EN
      if (irq_s && first_irq < 0) first_irq = k;
      if (k == 130) chk("irq_before_clear", irq_s, 1);
      if (k == 131) chk("irq_after_clear", irq_s, 0);
      irq_clear_s = (k == 130);
`endif
      tick();
    end
    chk("s_frame_start_count", fs_cnt, 1);
    chk("s_line_start_count", ls_cnt, 6);
    chk("s_de_count", de_cnt, 60);
    chk("s_de_first", first_de, 3);
    chk("s_hs_count", hs_cnt, 39);
    chk("s_vs_count", vs_cnt, 40);
    chk("s_vs_first", first_vs, 163);

    // Wrap from the last count of the frame back to (0,0).
    chk("wrap_frame_start", fs_s, 1);
    chk("wrap_fetch_x", fx_s, 0);
    chk("wrap_fetch_y", fy_s, 0);
    chk("wrap_fetch_valid", fv_s, 1);
    tick();
    chk("wrap_frame_start_drop", fs_s, 0);
    chk("wrap_fetch_x_next", fx_s, 1);

`ifdef KFTVGA_VBLANK_IRQ_EN
    chk("irq_first_rise", first_irq, 121);
    repeat (380 - 261) tick();
    chk("irq_cleared_until_set", irq_s, 0);
    irq_clear_s = 1'b1;
    tick();
    chk("irq_set_wins", irq_s, 1);
    tick();
    chk("irq_clear_again", irq_s, 0);
    irq_clear_s = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
